// File: rtl/lift_dispatch_pkg.sv
// Shared types and helpers for the hall-call dispatcher.
//   disp_state_e  : search FSM states
//   index_width   : $clog2 with a 1-bit floor for degenerate counts
//   floor_width   : bits needed to hold a floor number
//   cost_width    : bits needed to hold a cost (distance + direction penalty)
//   onehot_to_idx : encodes a one-hot floor_sense vector (up to MAX_FLOORS)
package lift_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EVAL   = 2'd2,
    ST_COMMIT = 2'd3
  } disp_state_e;

  localparam int DEF_N_FLOORS = 12;
  localparam int DEF_N_LIFTS  = 10;
  localparam int MAX_FLOORS   = 64;
  localparam int IDX_W        = $clog2(MAX_FLOORS);

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int floor_width(input int n_floors);
    return index_width(n_floors);
  endfunction

  // Worst-case cost is (n_floors-1) + n_floors, which always fits here.
  function automatic int cost_width(input int n_floors);
    return index_width(2 * n_floors);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dispatch_cost_calc.sv
// Combinational nearest-car cost of one lift for one hall call.
//   i_last_floor : last floor the car was seen at
//   i_motion     : car is moving
//   i_direction  : 1 = car travelling up, 0 = down
//   i_call_floor : floor of the hall call
//   i_call_up    : 1 = up call, 0 = down call
//   o_cost       : |last_floor - call_floor|, plus N_FLOORS when a moving
//                  car is heading away or would pass the floor the wrong way
module dispatch_cost_calc
  import lift_dispatch_pkg::*;
#(
  parameter  int N_FLOORS = DEF_N_FLOORS,
  localparam int FLOOR_W  = floor_width(N_FLOORS),
  localparam int COST_W   = cost_width(N_FLOORS)
) (
  input  logic [FLOOR_W-1:0] i_last_floor,
  input  logic               i_motion,
  input  logic               i_direction,
  input  logic [FLOOR_W-1:0] i_call_floor,
  input  logic               i_call_up,
  output logic [COST_W-1:0]  o_cost
);

  logic [FLOOR_W-1:0] w_dist;
  logic               w_away;
  logic               w_penalty;

  always_comb begin
    w_dist = (i_last_floor >= i_call_floor) ? (i_last_floor - i_call_floor)
                                            : (i_call_floor - i_last_floor);
    w_away = i_direction ? (i_last_floor > i_call_floor)
                         : (i_last_floor < i_call_floor);
    // A car approaching the floor against the call direction cannot stop
    // usefully for it, so it is penalised just like a car heading away.
    w_penalty = i_motion & (w_away | (i_direction != i_call_up));
    o_cost    = COST_W'(w_dist) + (w_penalty ? COST_W'(N_FLOORS) : '0);
  end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Group dispatcher for a lift bank: latches hall calls, assigns each pending
// call to one car by a sequential nearest-car search, clears calls on service.
//   clk, reset            : clock, asynchronous active-low reset
//   up_rqst, dn_rqst      : hall buttons, one bit per floor
//   floor_sense           : per-car one-hot position (zero between floors)
//   direction/motion/door_open : per-car status
//   up_assign, dn_assign  : per-car assigned calls
//   global_*_rqst_status  : pending calls (hall lamps)
//   busy                  : search in progress
module hall_call_dispatcher
  import lift_dispatch_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int N_LIFTS  = DEF_N_LIFTS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_FLOORS-1:0]                up_rqst,
  input  logic [N_FLOORS-1:0]                dn_rqst,
  input  logic [N_LIFTS-1:0][N_FLOORS-1:0]   floor_sense,
  input  logic [N_LIFTS-1:0]                 direction,
  input  logic [N_LIFTS-1:0]                 motion,
  input  logic [N_LIFTS-1:0]                 door_open,
  output logic [N_LIFTS-1:0][N_FLOORS-1:0]   up_assign,
  output logic [N_LIFTS-1:0][N_FLOORS-1:0]   dn_assign,
  output logic [N_FLOORS-1:0]                global_up_rqst_status,
  output logic [N_FLOORS-1:0]                global_dn_rqst_status,
  output logic                               busy
);

  localparam int FLOOR_W = floor_width(N_FLOORS);
  localparam int COST_W  = cost_width(N_FLOORS);
  localparam int LIFT_W  = index_width(N_LIFTS);
  localparam int N_SLOTS = 2 * N_FLOORS;
  localparam int SLOT_W  = index_width(N_SLOTS);

  // No up button on the top floor, no down button on the bottom floor.
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0]                r_pending_up, r_pending_dn;
  logic [N_LIFTS-1:0][N_FLOORS-1:0]   r_up_assign, r_dn_assign;
  logic [N_LIFTS-1:0][FLOOR_W-1:0]    r_last_floor;
  disp_state_e                        r_state;
  logic [SLOT_W-1:0]                  r_scan_ptr, r_slot;
  logic [LIFT_W-1:0]                  r_lift_idx, r_best_lift;
  logic [COST_W-1:0]                  r_best_cost;

  logic [N_FLOORS-1:0]                w_serve_up, w_serve_dn;
  logic [N_FLOORS-1:0]                w_held_up, w_held_dn;
  logic [N_SLOTS-1:0]                 w_unassigned;
  logic [N_LIFTS-1:0][FLOOR_W-1:0]    w_enc_floor;
  logic                               w_found;
  logic [SLOT_W-1:0]                  w_pick, w_ptr_next;
  logic                               w_call_up, w_call_pending;
  logic [FLOOR_W-1:0]                 w_call_floor;
  logic [COST_W-1:0]                  w_cost;
  logic [N_LIFTS-1:0][N_FLOORS-1:0]   w_up_set, w_dn_set;

  // Service detection and per-floor "some car already holds it" summaries.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_serve_up = '0;
    w_serve_dn = '0;
    w_held_up  = '0;
    w_held_dn  = '0;
    for (int l = 0; l < N_LIFTS; l++) begin
      if (door_open[l]) begin
        if (direction[l]) w_serve_up = w_serve_up | floor_sense[l];
        else              w_serve_dn = w_serve_dn | floor_sense[l];
      end
      w_held_up = w_held_up | r_up_assign[l];
      w_held_dn = w_held_dn | r_dn_assign[l];
      w_enc_floor[l] = FLOOR_W'(onehot_to_idx(MAX_FLOORS'(floor_sense[l])));
    end
  end

  // Slot space: up floors in the low half, down floors in the high half.
  assign w_unassigned = {r_pending_dn & ~w_held_dn, r_pending_up & ~w_held_up};

  // Round-robin: first unassigned slot at or after the scan pointer.
  always_comb begin
    int s;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      s = int'(r_scan_ptr) + i;
      if (s >= N_SLOTS) s = s - N_SLOTS;
      if (!w_found && w_unassigned[s]) begin
        w_found = 1'b1;
        w_pick  = SLOT_W'(s);
      end
    end
    w_ptr_next = (w_pick == SLOT_W'(N_SLOTS - 1)) ? '0 : w_pick + SLOT_W'(1);
  end

  always_comb begin
    if (r_slot < SLOT_W'(N_FLOORS)) begin
      w_call_up    = 1'b1;
      w_call_floor = FLOOR_W'(r_slot);
    end else begin
      w_call_up    = 1'b0;
      w_call_floor = FLOOR_W'(r_slot - SLOT_W'(N_FLOORS));
    end
    w_call_pending = w_call_up ? r_pending_up[w_call_floor] : r_pending_dn[w_call_floor];
  end

  // One cost unit, time-shared across cars by the EVAL lift index.
  dispatch_cost_calc #(.N_FLOORS(N_FLOORS)) u_cost (
    .i_last_floor (r_last_floor[r_lift_idx]),
    .i_motion     (motion[r_lift_idx]),
    .i_direction  (direction[r_lift_idx]),
    .i_call_floor (w_call_floor),
    .i_call_up    (w_call_up),
    .o_cost       (w_cost)
  );

  // The slot may have been served during EVAL; only a still-pending call
  // is committed, so no stale assignment appears.
  always_comb begin
    w_up_set = '0;
    w_dn_set = '0;
    if (r_state == ST_COMMIT && w_call_pending) begin
      if (w_call_up) w_up_set[r_best_lift][w_call_floor] = 1'b1;
      else           w_dn_set[r_best_lift][w_call_floor] = 1'b1;
    end
  end

  // Call bookkeeping. Service is applied last so it wins over a same-cycle
  // button press or commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the assignment and pending arrays are reset explicitly because
      // they drive the outputs and the search; they are flops, not a RAM.
      r_pending_up <= '0;
      r_pending_dn <= '0;
      r_up_assign  <= '0;
      r_dn_assign  <= '0;
      r_last_floor <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic so every
      // register samples the pre-edge values of the others.
      r_pending_up <= (r_pending_up | (up_rqst & UP_MASK)) & ~w_serve_up;
      r_pending_dn <= (r_pending_dn | (dn_rqst & DN_MASK)) & ~w_serve_dn;
      for (int l = 0; l < N_LIFTS; l++) begin
        r_up_assign[l] <= (r_up_assign[l] | w_up_set[l]) & ~w_serve_up;
        r_dn_assign[l] <= (r_dn_assign[l] | w_dn_set[l]) & ~w_serve_dn;
        if (|floor_sense[l]) r_last_floor[l] <= w_enc_floor[l];
      end
    end
  end

  // Search FSM: IDLE -> SELECT -> EVAL (one car per cycle) -> COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_scan_ptr  <= '0;
      r_slot      <= '0;
      r_lift_idx  <= '0;
      r_best_lift <= '0;
      r_best_cost <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_unassigned) r_state <= ST_SELECT;
        end
        ST_SELECT: begin
          if (w_found) begin
            r_slot      <= w_pick;
            r_scan_ptr  <= w_ptr_next;
            r_lift_idx  <= '0;
            r_best_lift <= '0;
            r_best_cost <= '1;
            r_state     <= ST_EVAL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          // Strictly-less keeps the lowest-indexed car on a tie.
          if (w_cost < r_best_cost) begin
            r_best_cost <= w_cost;
            r_best_lift <= r_lift_idx;
          end
          if (r_lift_idx == LIFT_W'(N_LIFTS - 1)) r_state <= ST_COMMIT;
          else                                    r_lift_idx <= r_lift_idx + LIFT_W'(1);
        end
        ST_COMMIT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign up_assign             = r_up_assign;
  assign dn_assign             = r_dn_assign;
  assign global_up_rqst_status = r_pending_up;
  assign global_dn_rqst_status = r_pending_dn;
  assign busy                  = (r_state != ST_IDLE);

endmodule

// File: doc/hall_call_dispatcher.md
Name: hall_call_dispatcher

Overview:
- Group dispatcher for a multi-lift bank.
- Latches floor hall calls (up/dn buttons) into pending registers and assigns each pending call to exactly one lift using a sequential nearest-car cost search.
- Publishes per-lift up/dn assignment masks that feed each lift's stop logic, plus the global hall-lamp status.
- Clears calls when the assigned or any lift services the floor in the matching direction.

Parameters:
- N_FLOORS, 12, number of floors (>=2)
- N_LIFTS, 10, number of cars (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- up_rqst  input  N_FLOORS  hall up buttons, level, one bit per floor
- dn_rqst  input  N_FLOORS  hall down buttons, level, one bit per floor
- floor_sense  input  [N_LIFTS] x N_FLOORS  one-hot car position; all-zero between floors
- direction  input  N_LIFTS  1=up, 0=down, per car
- motion  input  N_LIFTS  1=car moving
- door_open  input  N_LIFTS  1=door open
- up_assign  output  [N_LIFTS] x N_FLOORS  up calls assigned to each car
- dn_assign  output  [N_LIFTS] x N_FLOORS  down calls assigned to each car
- global_up_rqst_status  output  N_FLOORS  pending up calls (hall lamps)
- global_dn_rqst_status  output  N_FLOORS  pending down calls
- busy  output  1  dispatch search in progress

Behaviour:
- Reset (reset=0, async): all pending, assignment and last_floor registers 0; FSM=IDLE; scan pointer 0; all outputs 0.
- Latching: pending_up[f] set the cycle after up_rqst[f]=1; pending_dn likewise. up_rqst[N_FLOORS-1] and dn_rqst[0] are ignored.
- Service and clear:
  - Up call at f is served when, for any car L, floor_sense[L][f]=1, door_open[L]=1 and direction[L]=1. Down calls use direction[L]=0.
  - Next cycle: pending bit and that call's assignment bit in every car cleared.
  - Set and serve in the same cycle: serve wins, bit stays 0.
- last_floor[L] (clog2(N_FLOORS) bits): loads the encoded floor_sense[L] whenever it is nonzero; holds while between floors.
- A call is "unassigned" when pending and no car holds its assignment bit.
- FSM:
  - IDLE: if any unassigned call exists, go to SELECT.
  - SELECT, 1 cycle: round-robin pick of the first unassigned slot at or after the scan pointer. Slot space is 2*N_FLOORS: up floors 0..N-1, then dn floors 0..N-1, wrapping. Latch slot; pointer = slot+1 (mod 2*N_FLOORS). Go to EVAL, lift index 0, best_cost = all-ones.
  - EVAL, N_LIFTS cycles, one car per cycle:
    - cost = |last_floor - f|.
    - Add N_FLOORS if motion=1 and the car is heading away from f, or the car passes f in the opposite call direction.
    - Strictly-less comparison, so ties go to the lowest index.
    - After car N_LIFTS-1, go to COMMIT.
  - COMMIT, 1 cycle: if the slot is still pending, set the assign bit for best car; else drop. Return to IDLE.
- Cost width: clog2(2*N_FLOORS) bits; no overflow.
- busy=1 in SELECT/EVAL/COMMIT.
- Worst-case latency, unassigned call to assign bit visible: N_LIFTS+3 cycles from IDLE.
- Only one call is dispatched per search. Calls arriving mid-search wait their turn.
- A clear during EVAL of the same slot: COMMIT drops, no stale assignment.
- Assignments are never reassigned.
- Reset asserted mid-search aborts immediately. All state returns to reset values.
- global_*_rqst_status = pending registers.

Decomposition:
- Package lift_dispatch_pkg holds:
  - FSM state enum (IDLE, SELECT, EVAL, COMMIT)
  - cost/floor width localparams derived via $clog2
  - function onehot_to_idx
- One sub-module, dispatch_cost_calc: combinational cost of one car for one call (last_floor, motion, direction, call floor, call dir -> cost). It is instantiated once and muxed by the EVAL lift index.

Test Plan (N_FLOORS=8, N_LIFTS=3):
1. Idle cars at floors 0, 4, 7; pulse up_rqst[5] -> global_up_rqst_status[5]=1 next cycle; up_assign[1][5]=1 exactly 6 cycles later; no other car assigned.
2. Cars at 2 and 6, both idle; dn_rqst[4] -> tie at cost 2, dn_assign[0][4]=1.
3. Car0 at 3 moving up, car1 at 1 idle; up_rqst[2] -> car0 cost 1+8=9, car1 cost 1, up_assign[1][2]=1.
4. Assigned up call at 5 for car1; car1 floor_sense=5, direction=1, door_open=1 -> up_assign[1][5] and status[5] clear next cycle. Same stimulus with direction=0 -> call remains.
5. up_rqst[7] and dn_rqst[0] pulsed -> status stays 0 and busy never asserts. Simultaneous up_rqst[3], dn_rqst[3] and up_rqst[6] -> three sequential searches in slot order up3, up6, dn3.
6. Assert reset during EVAL -> all assign/status outputs 0 and busy=0 immediately. After release with up_rqst[2] still held -> fresh dispatch completes normally.
